// File: rtl/mmio_pkg.sv
// Shared constants and state encoding for the CPU-to-peripheral MMIO bridge.
package mmio_pkg;

  localparam int unsigned DefAddrW   = 16;
  localparam int unsigned DefDataW   = 16;
  localparam int unsigned DefRegMsb  = 15;
  localparam int unsigned DefRegLsb  = 13;
  localparam int unsigned DefNumCh   = 4;
  localparam int unsigned DefTimeout = 15;

  // Returned for unmapped or timed-out loads; sliced down to DATA_W by users.
  localparam logic [63:0] MMIO_ERR_DATA = '1;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StReq  = 2'd1;
  localparam state_t StDone = 2'd2;

  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/mmio_decode.sv
// Region decode: splits the CPU address space into internal memory and external channels.
module mmio_decode
  import mmio_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned REG_MSB = DefRegMsb,
  parameter int unsigned REG_LSB = DefRegLsb,
  parameter int unsigned NUM_CH  = DefNumCh,
  parameter int unsigned CH_W    = ch_width(DefNumCh)
) (
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              is_ext,
  output logic              is_mapped,
  output logic [CH_W-1:0]   ch_idx
);

  localparam int unsigned RegW = REG_MSB - REG_LSB + 1;

  logic [RegW-1:0]   region;
  logic [RegW-1:0]   region_m1;
  logic [ADDR_W-1:0] unused_addr;

  assign region      = cpu_addr[REG_MSB:REG_LSB];
  assign region_m1   = region - RegW'(1);
  assign is_ext      = (region != '0);
  assign is_mapped   = is_ext && (region <= RegW'(NUM_CH));
  assign ch_idx      = CH_W'(region_m1);
  assign unused_addr = cpu_addr;

endmodule

// File: rtl/mmio_bridge.sv
// MMIO bridge: routes CPU data accesses to internal memory or to a handshaked external channel.
// Optional wait-state timeout is built when MMIO_TIMEOUT_EN is defined.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned REG_MSB = DefRegMsb,
  parameter int unsigned REG_LSB = DefRegLsb,
  parameter int unsigned NUM_CH  = DefNumCh,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_stall,
  output logic                     dm_re,
  output logic                     dm_we,
  input  logic [DATA_W-1:0]        dm_rdata,
  output logic [NUM_CH-1:0]        ch_req,
  output logic                     ch_we,
  output logic [ADDR_W-1:0]        ch_addr,
  output logic [DATA_W-1:0]        ch_wdata,
  input  logic [NUM_CH-1:0]        ch_ack,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
  output logic                     err,
  input  logic                     err_clr
);

  localparam int unsigned ChW = ch_width(NUM_CH);

  logic            is_ext;
  logic            is_mapped;
  logic [ChW-1:0]  dec_idx;

  mmio_decode #(
    .ADDR_W  (ADDR_W),
    .REG_MSB (REG_MSB),
    .REG_LSB (REG_LSB),
    .NUM_CH  (NUM_CH),
    .CH_W    (ChW)
  ) u_decode (
    .cpu_addr  (cpu_addr),
    .is_ext    (is_ext),
    .is_mapped (is_mapped),
    .ch_idx    (dec_idx)
  );

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   ch_req_q, ch_req_d;
  logic                ch_we_q, ch_we_d;
  logic [ADDR_W-1:0]   ch_addr_q, ch_addr_d;
  logic [DATA_W-1:0]   ch_wdata_q, ch_wdata_d;
  logic [ChW-1:0]      ch_idx_q, ch_idx_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                err_set;

  logic                access;
  logic                ext_start;
  logic [NUM_CH-1:0]   req_onehot;
  logic                ack_hit;
  logic [DATA_W-1:0]   sel_rdata;

`ifdef MMIO_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
`else
  localparam int unsigned UnusedTimeout = TIMEOUT;
`endif

  assign access    = cpu_re | cpu_we;
  assign ext_start = (state_q == StIdle) && is_ext && access;

  always_comb begin
    req_onehot = '0;
    ack_hit    = 1'b0;
    sel_rdata  = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (dec_idx == ChW'(i)) req_onehot[i] = 1'b1;
      if (ch_idx_q == ChW'(i)) begin
        ack_hit   = ch_ack[i];
        sel_rdata = ch_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_req_d   = ch_req_q;
    ch_we_d    = ch_we_q;
    ch_addr_d  = ch_addr_q;
    ch_wdata_d = ch_wdata_q;
    ch_idx_d   = ch_idx_q;
    rdata_d    = rdata_q;
    err_set    = 1'b0;
`ifdef MMIO_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (ext_start) begin
          ch_addr_d  = cpu_addr;
          ch_wdata_d = cpu_wdata;
          // A simultaneous load and store is treated as a store.
          ch_we_d    = cpu_we;
          ch_idx_d   = dec_idx;
          if (is_mapped) begin
            state_d  = StReq;
            ch_req_d = req_onehot;
`ifdef MMIO_TIMEOUT_EN
            tmo_d    = '0;
`endif
          end else begin
            state_d = StDone;
            rdata_d = MMIO_ERR_DATA[DATA_W-1:0];
            err_set = 1'b1;
          end
        end
      end
      StReq: begin
        if (ack_hit) begin
          if (!ch_we_q) rdata_d = sel_rdata;
          ch_req_d = '0;
          state_d  = StDone;
        end
`ifdef MMIO_TIMEOUT_EN
        else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          rdata_d  = MMIO_ERR_DATA[DATA_W-1:0];
          err_set  = 1'b1;
          ch_req_d = '0;
          state_d  = StDone;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
`endif
      end
      // The CPU consumes the result now; returning to idle unconditionally keeps the
      // still-held request from being relaunched.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Set takes priority over a same-cycle clear.
  assign err_d = err_set | (err_q & ~err_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ch_req_q   <= '0;
      ch_we_q    <= 1'b0;
      ch_addr_q  <= '0;
      ch_wdata_q <= '0;
      ch_idx_q   <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_req_q   <= ch_req_d;
      ch_we_q    <= ch_we_d;
      ch_addr_q  <= ch_addr_d;
      ch_wdata_q <= ch_wdata_d;
      ch_idx_q   <= ch_idx_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

`ifdef MMIO_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  assign cpu_stall = ext_start || (state_q == StReq);
  assign dm_re     = (state_q == StIdle) && !is_ext && cpu_re;
  assign dm_we     = (state_q == StIdle) && !is_ext && cpu_we;
  assign cpu_rdata = (state_q == StDone) ? rdata_q : dm_rdata;
  assign ch_req    = ch_req_q;
  assign ch_we     = ch_we_q;
  assign ch_addr   = ch_addr_q;
  assign ch_wdata  = ch_wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed vector table, random transactions against a
// latency/response model, plus reset-in-flight and timeout sequences.
module tb_mmio_bridge;

  localparam int Tmo = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_re;
  logic        cpu_we;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic        dm_re;
  logic        dm_we;
  logic [15:0] dm_rdata;
  logic [3:0]  ch_req;
  logic        ch_we;
  logic [15:0] ch_addr;
  logic [15:0] ch_wdata;
  logic [3:0]  ch_ack;
  logic [63:0] ch_rdata;
  logic        err;
  logic        err_clr;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_cap;
  logic        m_err;

  always #5 clk = ~clk;

  mmio_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dm_re     (dm_re),
    .dm_we     (dm_we),
    .dm_rdata  (dm_rdata),
    .ch_req    (ch_req),
    .ch_we     (ch_we),
    .ch_addr   (ch_addr),
    .ch_wdata  (ch_wdata),
    .ch_ack    (ch_ack),
    .ch_rdata  (ch_rdata),
    .err       (err),
    .err_clr   (err_clr)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        re;
    logic        we;
    int          wait_n;  // negative: channel never acknowledges
    logic [15:0] rd;
    logic        clr;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    cpu_re  = 1'b0;
    cpu_we  = 1'b0;
    err_clr = 1'b0;
    ch_ack  = '0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_cap = '0;
    m_err = 1'b0;
  endtask

  // Drives one CPU access from the idle state and checks every cycle until it retires.
  task automatic xact(input vec_t v);
    logic [2:0] r;
    logic       ext, mapped, acc, hit, done;
    logic [3:0] oh;
    int         k, idx;
    r      = v.addr[15:13];
    ext    = (r != 3'd0);
    mapped = ext && (r <= 3'd4);
    acc    = v.re | v.we;
    oh     = 4'b0;
    idx    = int'(r) - 1;
    if (mapped) oh[idx] = 1'b1;

    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    cpu_re    = v.re;
    cpu_we    = v.we;
    err_clr   = v.clr;
    dm_rdata  = 16'($urandom);
    ch_ack    = 4'($urandom);
    ch_rdata  = {$urandom(), $urandom()};
    @(negedge clk);
    chk("detect_stall", cpu_stall, ext && acc);
    chk("detect_req", ch_req, 4'b0);
    chk("dm_re", dm_re, !ext && v.re);
    chk("dm_we", dm_we, !ext && v.we);
    chk("idle_rdata", cpu_rdata, dm_rdata);
    chk("detect_err", err, m_err);
    @(posedge clk);
    #1;
    m_err   = (ext && acc && !mapped) ? 1'b1 : (v.clr ? 1'b0 : m_err);
    err_clr = 1'b0;
    ch_ack  = '0;
    if (!(ext && acc)) begin
      cpu_re = 1'b0;
      cpu_we = 1'b0;
      return;
    end

    if (!mapped) begin
      m_cap = 16'hFFFF;
    end else begin
      k    = 0;
      done = 1'b0;
      while (!done) begin
        k++;
        ch_rdata = {$urandom(), $urandom()};
        ch_rdata[idx*16 +: 16] = v.rd;
        hit    = (v.wait_n >= 0) && (k == v.wait_n + 1);
        ch_ack = (4'($urandom) & ~oh) | (hit ? oh : 4'b0);
        @(negedge clk);
        chk("req_stall", cpu_stall, 1'b1);
        chk("req_onehot", ch_req, oh);
        chk("req_addr", ch_addr, v.addr);
        chk("req_we", ch_we, v.we);
        if (v.we) chk("req_wdata", ch_wdata, v.wdata);
        chk("req_err", err, m_err);
        chk("req_dm", {dm_re, dm_we}, 2'b00);
        @(posedge clk);
        #1;
        ch_ack = '0;
        if (hit) begin
          done = 1'b1;
          if (!v.we) m_cap = v.rd;
        end
`ifdef MMIO_TIMEOUT_EN
        else if (k == Tmo) begin
          done  = 1'b1;
          m_cap = 16'hFFFF;
          m_err = 1'b1;
        end
`else
        else if (k >= 110) begin
          done = 1'b1;
        end
`endif
      end
`ifndef MMIO_TIMEOUT_EN
      if (v.wait_n < 0) begin
        do_reset();
        @(negedge clk);
        chk("hang_reset_stall", cpu_stall, 1'b0);
        chk("hang_reset_req", ch_req, 4'b0);
        @(posedge clk);
        #1;
        return;
      end
`endif
    end

    ch_ack = 4'($urandom);
    @(negedge clk);
    chk("done_stall", cpu_stall, 1'b0);
    chk("done_req", ch_req, 4'b0);
    chk("done_rdata", cpu_rdata, m_cap);
    chk("done_err", err, m_err);
    @(posedge clk);
    #1;
    ch_ack = '0;
    cpu_re = 1'b0;
    cpu_we = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    vec_t rv;
    vecs[0] = '{16'h2010, 16'h5555, 1'b0, 1'b1, 0, 16'h1111, 1'b0};  // write: capture stays 0
    vecs[1] = '{16'h0100, 16'h1234, 1'b0, 1'b1, 0, 16'h0000, 1'b0};  // internal store
    vecs[2] = '{16'h2004, 16'h0000, 1'b1, 1'b0, 3, 16'hBEEF, 1'b0};  // ch0 read, 3 waits
    vecs[3] = '{16'h6000, 16'h00AA, 1'b0, 1'b1, 0, 16'h3333, 1'b0};  // ch2 write, immediate
    vecs[4] = '{16'hA000, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 1'b0};  // unmapped read
    vecs[5] = '{16'h0200, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 1'b1};  // internal read + err_clr
    vecs[6] = '{16'hE000, 16'h4321, 1'b0, 1'b1, 0, 16'h0000, 1'b1};  // unmapped, set beats clr
    vecs[7] = '{16'h8002, 16'h9999, 1'b1, 1'b1, 1, 16'h7777, 1'b0};  // re&we on ch3 -> write
    vecs[8] = '{16'h4000, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 1'b1};  // ext addr, no access
    vecs[9] = '{16'h4ABC, 16'h0000, 1'b1, 1'b0, 2, 16'h0F0F, 1'b0};  // ch1 read, 2 waits

    cpu_addr  = '0;
    cpu_wdata = '0;
    dm_rdata  = '0;
    ch_rdata  = '0;
    do_reset();
    @(negedge clk);
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_req", ch_req, 4'b0);
    chk("rst_we", ch_we, 1'b0);
    chk("rst_addr", ch_addr, 16'h0);
    chk("rst_wdata", ch_wdata, 16'h0);
    chk("rst_err", err, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) xact(vecs[i]);

    // Reset while a request is outstanding abandons it.
    rv = '{16'hA000, 16'h0, 1'b1, 1'b0, 0, 16'h0, 1'b0};
    xact(rv);
    cpu_addr = 16'h2004;
    cpu_re   = 1'b1;
    @(negedge clk);
    chk("rstreq_detect", cpu_stall, 1'b1);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    cpu_re = 1'b0;
    @(negedge clk);
    chk("rstreq_inflight", ch_req, 4'b0001);
    chk("rstreq_err_before", err, 1'b1);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_cap = '0;
    m_err = 1'b0;
    @(negedge clk);
    chk("rstreq_req", ch_req, 4'b0);
    chk("rstreq_stall", cpu_stall, 1'b0);
    chk("rstreq_err", err, 1'b0);
    @(posedge clk);
    #1;

    // Channel that never answers.
    rv = '{16'h2000, 16'h0, 1'b1, 1'b0, -1, 16'h0, 1'b0};
    xact(rv);

    for (int i = 0; i < 150; i++) begin
      rv.addr   = 16'($urandom);
      rv.wdata  = 16'($urandom);
      rv.re     = 1'($urandom);
      rv.we     = 1'($urandom);
      rv.wait_n = $urandom_range(0, 5);
      rv.rd     = 16'($urandom);
      rv.clr    = ($urandom_range(0, 3) == 0);
      xact(rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Parametrised memory-mapped I/O bridge between the pipelined CPU's EX/DM-stage data port and up to NUM_CH external peripheral channels. Addresses with a nonzero region field go external and every other address goes to internal data memory. External accesses run a request/acknowledge handshake with variable wait states, stall the CPU until completion, and can optionally time out.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- REG_MSB, 15, top bit of region field
- REG_LSB, 13, bottom bit of region field; region value r=1..NUM_CH selects channel r-1
- NUM_CH, 4, external channels; 1 ≤ NUM_CH ≤ 2^(REG_MSB-REG_LSB+1)-1
- TIMEOUT, 15, wait-state limit in cycles (≥1)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high; one clock, synchronous active-high reset
- cpu_addr  in  ADDR_W  access address
- cpu_wdata  in  DATA_W  store data
- cpu_re / cpu_we  in  1  load / store request; held stable by the CPU while cpu_stall=1
- cpu_rdata  out  DATA_W  load result
- cpu_stall  out  1  freeze pipeline
- dm_re / dm_we  out  1  qualified internal memory enables
- dm_rdata  in  DATA_W  internal memory read data
- ch_req  out  NUM_CH  one-hot channel request
- ch_we  out  1  request is a write
- ch_addr  out  ADDR_W  latched address
- ch_wdata  out  DATA_W  latched write data
- ch_ack  in  NUM_CH  per-channel completion
- ch_rdata  in  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
- err  out  1  sticky bus error
- err_clr  in  1  clears err

## Operation
- Region r = cpu_addr[REG_MSB:REG_LSB].
  - r==0: internal access. dm_re=cpu_re and dm_we=cpu_we (gated only in state IDLE). cpu_rdata=dm_rdata combinationally. cpu_stall=0.
- States: IDLE, REQ, DONE.
- IDLE with r≠0 and (cpu_re|cpu_we):
  - cpu_stall=1 combinationally in the same cycle.
  - Latch addr, wdata, we and channel.
  - If re and we are both set, the access is a write.
  - 1≤r≤NUM_CH: go to REQ.
  - r>NUM_CH (unmapped): go to DONE with rdata=all-ones and set err. No channel request is issued.
- REQ:
  - ch_req[ch]=1 (registered); ch_addr, ch_wdata and ch_we come from the latches. cpu_stall=1.
  - ch_ack[ch]=1 at an edge: capture ch_rdata slice (reads only; writes capture nothing), go to DONE.
  - ch_req must drop in DONE.
  - Acks from other channels, and any ack outside REQ, are ignored.
- DONE:
  - cpu_stall=0; cpu_rdata=captured register.
  - The CPU advances this cycle. Next state is IDLE unconditionally, so the held request is never relaunched.
- err: set on unmapped access or timeout; cleared by err_clr. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values: state IDLE, ch_req=0, ch_we=0, ch_addr=0, ch_wdata=0, capture register 0, err=0, timeout counter 0. cpu_stall=0 unless IDLE sees an external access.
- Internal access: zero stall, combinational path.
- External access with ack in the first REQ cycle: stall for 2 cycles (detect cycle + REQ), data in the 3rd cycle (DONE). Each additional wait state adds one cycle.
- Unmapped access: 1 stall cycle, then DONE.
- Reset mid-REQ: ch_req is low from the next cycle, state returns to IDLE, and the transaction is lost.
- Back-to-back external accesses: the second is detected in IDLE the cycle after DONE, leaving a minimum of one non-stall cycle between them.

## Configuration
- MMIO_TIMEOUT_EN defined: counter increments each REQ cycle. When TIMEOUT consecutive REQ cycles pass with no ack:
  - go to DONE with rdata=all-ones;
  - set err;
  - drop ch_req.
- MMIO_TIMEOUT_EN undefined: REQ waits indefinitely. No counter is built. err is set only by unmapped accesses.

## Structure
- Package mmio_pkg holds:
  - state enum (IDLE/REQ/DONE);
  - MMIO_ERR_DATA constant (all-ones);
  - default parameter constants.
- Sub-module mmio_decode: combinational region decode. Outputs is_ext, is_mapped and channel index from cpu_addr.

## Test plan
- Internal: addr 0x0100, we=1, wdata 0x1234 → dm_we=1, ch_req=0, cpu_stall=0 throughout.
- External read: addr 0x2004, ch0 acks after 3 wait cycles with 0xBEEF → ch_req=0001 for 4 cycles, stall 5 cycles, cpu_rdata=0xBEEF in DONE, ch_addr=0x2004.
- External write, ch 2: addr 0x6000, wdata 0x00AA, immediate ack → ch_we=1, ch_wdata=0x00AA, 2 stall cycles. Spurious ch_ack[1] pulse is ignored.
- Unmapped (NUM_CH=4): addr 0xA000 read → no ch_req, 1 stall cycle, cpu_rdata=0xFFFF, err=1. err_clr then lowers err.
- Timeout (MMIO_TIMEOUT_EN, TIMEOUT=15): never ack → ch_req high 15 cycles, then cpu_rdata=0xFFFF and err=1. Without the macro: stall persists past 100 cycles.
- rst asserted during REQ → next cycle ch_req=0, cpu_stall=0, err=0.
